// File: rtl/lc3_mem_pkg.sv
// Shared constants and types for the LC-3 memory/I-O unit.
package lc3_mem_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        DEV_NONE,
        DEV_KBSR,
        DEV_KBDR,
        DEV_DSR,
        DEV_DDR,
        DEV_MCR
    } dev_t;

    function automatic dev_t decode_addr(input logic [15:0] addr);
        case (addr)
            KBSR_ADDR: return DEV_KBSR;
            KBDR_ADDR: return DEV_KBDR;
            DSR_ADDR:  return DEV_DSR;
            DDR_ADDR:  return DEV_DDR;
            MCR_ADDR:  return DEV_MCR;
            default:   return DEV_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// Memory-mapped device registers: keyboard, display and machine control.
module lc3_mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        access,
    input  logic        write,
    input  dev_t        dev,
    input  logic        wr_bit15,
    input  logic        wr_bit14,
    input  logic [7:0]  wr_char,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    input  logic        disp_ack,
    output logic [15:0] rdata,
    output logic        kb_int,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    output logic        halt
);

    logic       kb_ready_reg;
    logic       kb_ie_reg;
    logic [7:0] kbdr_reg;
    logic       disp_valid_reg;
    logic [7:0] disp_data_reg;
    logic       mcr_reg;
    logic       kbdr_read;
    logic       dev_write;

    assign kbdr_read = access && !write && (dev == DEV_KBDR);
    assign dev_write = access && write;

    // Display is ready exactly when no character is outstanding.
    always_comb begin
        rdata = 16'h0000;
        case (dev)
            DEV_KBSR: rdata = {kb_ready_reg, kb_ie_reg, 14'h0000};
            DEV_KBDR: rdata = {8'h00, kbdr_reg};
            DEV_DSR:  rdata = {~disp_valid_reg, 15'h0000};
            DEV_MCR:  rdata = {mcr_reg, 15'h0000};
            default:  rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_ready_reg   <= 1'b0;
            kb_ie_reg      <= 1'b0;
            kbdr_reg       <= 8'h00;
            disp_valid_reg <= 1'b0;
            disp_data_reg  <= 8'h00;
            mcr_reg        <= 1'b1;
        end else begin
            // A KBDR read frees the buffer in the same edge, so a coincident char is kept.
            if (kb_valid && (!kb_ready_reg || kbdr_read)) begin
                kbdr_reg     <= kb_data;
                kb_ready_reg <= 1'b1;
            end else if (kbdr_read) begin
                kb_ready_reg <= 1'b0;
            end

            if (dev_write && dev == DEV_KBSR)
                kb_ie_reg <= wr_bit14;
            if (dev_write && dev == DEV_MCR)
                mcr_reg <= wr_bit15;

            if (dev_write && dev == DEV_DDR && !disp_valid_reg) begin
                disp_data_reg  <= wr_char;
                disp_valid_reg <= 1'b1;
            end else if (disp_ack) begin
                disp_valid_reg <= 1'b0;
            end
        end
    end

    assign kb_int     = kb_ready_reg & kb_ie_reg;
    assign disp_valid = disp_valid_reg;
    assign disp_data  = disp_data_reg;
    assign halt       = ~mcr_reg;

endmodule

// File: rtl/lc3_memory_io.sv
// LC-3 memory/I-O unit: routes MAR/MDR accesses to the external bus or
// device registers and produces the microsequencer ready bit.
module lc3_memory_io
    import lc3_mem_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        i_CLK,
    input  logic        i_Reset_n,
    input  logic        i_MIO_EN,
    input  logic        i_R_W,
    input  logic [15:0] i_MAR,
    input  logic [15:0] i_MDR,
    output logic        o_R_Bit,
    output logic [15:0] o_MDR_in,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_rdata,
    output logic        o_bus_err,
    input  logic        i_kb_valid,
    input  logic [7:0]  i_kb_data,
    output logic        o_kb_int,
    output logic        o_disp_valid,
    output logic [7:0]  o_disp_data,
    input  logic        i_disp_ack,
    output logic        o_halt
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  count_reg;
    logic        req_reg;
    logic        we_reg;
    logic        err_reg;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic [15:0] mdr_reg;
    dev_t        dev;
    logic        dev_access;
    logic [15:0] dev_rdata;

    assign dev        = decode_addr(i_MAR);
    assign dev_access = (state_reg == IDLE) && i_MIO_EN && (dev != DEV_NONE);

    lc3_mmio_regs u_regs (
        .clk        (i_CLK),
        .rst_n      (i_Reset_n),
        .access     (dev_access),
        .write      (i_R_W),
        .dev        (dev),
        .wr_bit15   (i_MDR[15]),
        .wr_bit14   (i_MDR[14]),
        .wr_char    (i_MDR[7:0]),
        .kb_valid   (i_kb_valid),
        .kb_data    (i_kb_data),
        .disp_ack   (i_disp_ack),
        .rdata      (dev_rdata),
        .kb_int     (o_kb_int),
        .disp_valid (o_disp_valid),
        .disp_data  (o_disp_data),
        .halt       (o_halt)
    );

    always_ff @(posedge i_CLK or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_reg <= IDLE;
            count_reg <= 8'd0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= 16'h0000;
            wdata_reg <= 16'h0000;
            mdr_reg   <= 16'h0000;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_MIO_EN) begin
                        if (dev != DEV_NONE) begin
                            if (!i_R_W)
                                mdr_reg <= dev_rdata;
                            state_reg <= DONE;
                        end else begin
                            addr_reg  <= i_MAR;
                            wdata_reg <= i_MDR;
                            we_reg    <= i_R_W;
                            count_reg <= 8'd0;
                            req_reg   <= 1'b1;
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (i_mem_ack) begin
                        if (!we_reg)
                            mdr_reg <= i_mem_rdata;
                        req_reg   <= 1'b0;
                        state_reg <= DONE;
                    end else if (count_reg == TIMEOUT_LAST) begin
                        mdr_reg   <= 16'h0000;
                        err_reg   <= 1'b1;
                        req_reg   <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_R_Bit     = (state_reg == DONE);
    assign o_MDR_in    = mdr_reg;
    assign o_mem_req   = req_reg;
    assign o_mem_we    = we_reg;
    assign o_mem_addr  = addr_reg;
    assign o_mem_wdata = wdata_reg;
    assign o_bus_err   = err_reg;

endmodule

// File: doc/lc3_memory_io.md
# lc3_memory_io

Memory and I/O interface unit for the LC-3 core. It sits directly upstream of the microsequencer and produces the memory-ready bit (R) that the microsequencer tests while a memory microstate is held. It accepts MAR/MDR/MIO_EN/R_W from the datapath and control store. It then routes each access either to an external req/ack memory bus or to the internal memory-mapped device registers: KBSR, KBDR, DSR, DDR and MCR.

## Interface

Parameters:
- MEM_TIMEOUT, default 255: maximum number of WAIT cycles without an ack before the access is aborted. Range 1..255; the counter is 8 bits.

Ports:
- i_CLK, input, 1: the single clock.
- i_Reset_n, input, 1: asynchronous, active-low reset.
- i_MIO_EN, input, 1: memory access requested by the current microstate.
- i_R_W, input, 1: 1 = write, 0 = read.
- i_MAR, input, 16: access address.
- i_MDR, input, 16: write data.
- o_R_Bit, output, 1: access complete; goes to the microsequencer R input.
- o_MDR_in, output, 16: read data returned to the MDR mux.
- o_mem_req, output, 1: external bus request.
- o_mem_we, output, 1: external bus write enable.
- o_mem_addr, output, 16: external bus address.
- o_mem_wdata, output, 16: external bus write data.
- i_mem_ack, input, 1: single-cycle acknowledge from the external bus.
- i_mem_rdata, input, 16: external bus read data; valid when i_mem_ack is high.
- o_bus_err, output, 1: one-cycle pulse when an access times out.
- i_kb_valid, input, 1: keyboard character strobe.
- i_kb_data, input, 8: keyboard character.
- o_kb_int, output, 1: keyboard interrupt request, equal to KBSR[15] & KBSR[14].
- o_disp_valid, output, 1: display output request, held until acknowledged.
- o_disp_data, output, 8: display character.
- i_disp_ack, input, 1: display has consumed the character.
- o_halt, output, 1: MCR[15] == 0.

## Operation

- FSM states: IDLE, WAIT, DONE.
- Address decode, performed in IDLE:
  - xFE00 = KBSR, xFE02 = KBDR, xFE04 = DSR, xFE06 = DDR, xFFFE = MCR.
  - All other addresses go to the external bus.
- IDLE:
  - i_MIO_EN=1 with a device address: perform the register read or write, then go to DONE.
  - i_MIO_EN=1 with a bus address: latch addr, wdata and we; clear the timeout counter; go to WAIT.
- WAIT: o_mem_req=1.
  - On i_mem_ack: capture i_mem_rdata (reads only) and go to DONE.
  - When the counter reaches MEM_TIMEOUT without an ack: set o_MDR_in=x0000, pulse o_bus_err, go to DONE.
- DONE: o_R_Bit=1 for exactly one cycle, then IDLE. i_MIO_EN is ignored in DONE, because it is still the same microstate.
- o_R_Bit is decoded from the registered state only, so it is glitch-free.
- o_MDR_in holds the last read value until the next read completes. Writes leave it unchanged.
- Device registers:
  - KBSR: [15] ready, [14] IE (writable). All other bits read 0.
  - KBDR: {8'h00, char}.
  - DSR: [15] ready. All other bits read 0.
  - DDR: write-only; reads return x0000.
  - MCR: [15] clock enable, writable; other bits read 0.
- Keyboard capture:
  - i_kb_valid while KBSR[15]=0: load KBDR and set KBSR[15].
  - i_kb_valid while KBSR[15]=1: the character is dropped.
- Reading KBDR clears KBSR[15].
- KBDR read and i_kb_valid in the same cycle:
  - The read returns the old character.
  - The new character is loaded and KBSR[15] stays 1.
- Display output:
  - Writing DDR while DSR[15]=1: o_disp_data = i_MDR[7:0], o_disp_valid=1, DSR[15]=0.
  - On i_disp_ack: o_disp_valid=0, DSR[15]=1.
  - Writing DDR while DSR[15]=0: the write is ignored, but the access still completes with R.
- Writes to KBSR[15] or DSR[15] are ignored.

## Timing

- Reset, asynchronous: the FSM goes to IDLE and the registers take these values:
  - o_R_Bit=0, o_MDR_in=x0000.
  - o_mem_req=0, o_mem_we=0, o_mem_addr=x0000, o_mem_wdata=x0000.
  - o_bus_err=0, KBSR=x0000, KBDR=x0000.
  - DSR[15]=1, o_disp_valid=0, o_disp_data=x00.
  - MCR[15]=1, so o_halt=0.
- Reset mid-access: o_mem_req drops immediately, and a late i_mem_ack in IDLE is ignored.
- Device access latency: i_MIO_EN is sampled at edge N; o_R_Bit is high in cycle N+1.
- Bus access latency: o_mem_req is high from cycle N+1. If ack is sampled at edge M, o_R_Bit is high in cycle M+1 and o_mem_req is low from M+1.
- The minimum bus access is therefore 3 cycles, IDLE to IDLE.
- Back-to-back accesses need one intervening non-MIO microstate. An i_MIO_EN seen in IDLE always starts a new access.
- Timeout: o_bus_err and o_R_Bit are high in the same cycle.

## Structure

- Package lc3_mem_pkg holds:
  - the address constants KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR;
  - the FSM state enum.
- Sub-module lc3_mmio_regs holds the device registers, keyboard and display handshakes, and MCR.
- The parent module holds the FSM, address decode, bus port and timeout counter.

## Test plan

- Device read: set KBSR[15] via i_kb_valid with data x41, then read xFE02 → o_R_Bit high exactly 1 cycle after MIO_EN, o_MDR_in=x0041, KBSR[15]=0.
- Bus read: ack 4 cycles after o_mem_req with rdata x1234 → R pulses once, cycle after ack; o_MDR_in=x1234; req low in DONE.
- Timeout: MEM_TIMEOUT=3 and no ack → o_bus_err and o_R_Bit together; o_MDR_in=x0000.
- DDR write of x0058 with DSR ready → o_disp_valid=1, o_disp_data=x58, DSR reads x0000; after i_disp_ack, DSR reads x8000.
- Simultaneous KBDR read and i_kb_valid(x42) while holding x41 → read returns x0041; KBSR reads x8000; next KBDR read returns x0042.
- Write MCR=x0000 → o_halt=1. Assert i_Reset_n low during WAIT → o_mem_req=0 immediately and o_halt=0.
